// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sequencer sharing one combinational ALU between requesters
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_b,
    input  logic [NUM_REQ*4-1:0]          req_alu_ctrl,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_result,
    output logic                          rsp_zero,
    output logic [DATA_WIDTH-1:0]         alu_operand_a,
    output logic [DATA_WIDTH-1:0]         alu_operand_b,
    output logic [3:0]                    alu_ctrl,
    input  logic [DATA_WIDTH-1:0]         alu_result,
    input  logic                          alu_zero,
    output logic                          alu_active,
    output logic                          busy
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [IDX_W-1:0]        last_grant;
    logic [IDX_W-1:0]        owner;
    logic [IDX_W-1:0]        grant_idx;
    logic [NUM_REQ-1:0]      grant;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   sel_a;
    logic [DATA_WIDTH-1:0]   sel_b;
    logic [3:0]              sel_ctrl;

    // Walk from the farthest candidate to the nearest so the requester
    // closest after last_grant overrides any earlier pick.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] &&
                    ((int'(last_grant) + k == i) || (int'(last_grant) + k == i + NUM_REQ))) begin
                    grant        = '0;
                    grant[i]     = 1'b1;
                    grant_idx    = IDX_W'(i);
                end
            end
        end
    end

    // Held low during reset so a waiting requester never sees a false accept.
    assign req_ready = ((state_q == IDLE) && !rst) ? grant : '0;
    assign accept    = |req_ready;

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a    = req_operand_a[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b    = req_operand_b[i*DATA_WIDTH +: DATA_WIDTH];
                sel_ctrl = req_alu_ctrl[i*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready[owner]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (state_q == RESP) && (owner == IDX_W'(i));
        end
    end

    assign alu_active = (state_q == EXEC);
    assign busy       = (state_q != IDLE);

    // Operand registers load only on acceptance so the ALU inputs stay quiet when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant    <= LAST_IDX;
            owner         <= '0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_ctrl      <= '0;
            rsp_result    <= '0;
            rsp_zero      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_operand_a <= sel_a;
                alu_operand_b <= sel_b;
                alu_ctrl      <= sel_ctrl;
                owner         <= grant_idx;
                last_grant    <= grant_idx;
            end
            if (state_q == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [NR*DW-1:0] req_operand_a;
    logic [NR*DW-1:0] req_operand_b;
    logic [NR*4-1:0]  req_alu_ctrl;
    logic [NR-1:0]  rsp_valid;
    logic [NR-1:0]  rsp_ready;
    logic [DW-1:0]  rsp_result;
    logic           rsp_zero;
    logic [DW-1:0]  alu_operand_a;
    logic [DW-1:0]  alu_operand_b;
    logic [3:0]     alu_ctrl;
    logic [DW-1:0]  alu_result;
    logic           alu_zero;
    logic           alu_active;
    logic           busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
        .req_alu_ctrl(req_alu_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_active(alu_active), .busy(busy)
    );

    // Behavioural ALU; undefined codes give 0
    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [3:0] c);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1100: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_operand_a, alu_operand_b, alu_ctrl);
    assign alu_zero   = (alu_result == '0);

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (last + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [3:0] c);
        req_operand_a[i*DW +: DW] = a;
        req_operand_b[i*DW +: DW] = b;
        req_alu_ctrl[i*4 +: 4]    = c;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic run_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [3:0] c, output logic [DW-1:0] res, output logic z,
                          output int act);
        logic [NR-1:0] oh;
        int n;
        oh    = '0;
        oh[i] = 1'b1;
        set_req(i, a, b, c);
        rsp_ready = '1;
        req_valid = oh;
        #1;
        chk("op_ready", req_ready, oh);
        act = 0;
        cyc();
        req_valid = '0;
        n = 0;
        while (!rsp_valid[i] && n < 8) begin
            if (alu_active) act++;
            cyc();
            n++;
        end
        chk("op_rsp_seen", rsp_valid[i], 1'b1);
        chk("op_latency", n, 1);
        res = rsp_result;
        z   = rsp_zero;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] res;
        logic          z;
        int            act;
        logic [NR-1:0] exp_oh;
        logic [DW-1:0] ra, rb;
        logic [3:0]    rc;
        logic [DW-1:0] held;
        bit            pv [NR];
        logic [DW-1:0] pa [NR];
        logic [DW-1:0] pb [NR];
        logic [3:0]    pc [NR];
        int            last, own, age, w;
        bit            out;
        logic [DW-1:0] exp_res;

        // Reset state, with requests already pending
        rst           = 1'b1;
        req_valid     = '1;
        rsp_ready     = '0;
        req_operand_a = {$urandom, $urandom};
        req_operand_b = {$urandom, $urandom};
        req_alu_ctrl  = 8'h22;
        cyc();
        cyc();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_alu_a", alu_operand_a, 0);
        chk("rst_alu_b", alu_operand_b, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_alu_active", alu_active, 0);
        chk("rst_busy", busy, 0);
        rst       = 1'b0;
        req_valid = '0;
        #1;

        // Single op: ADD 5+7
        set_req(0, 5, 7, OP_ADD);
        rsp_ready = '1;
        req_valid = 2'b01;
        #1;
        chk("single_ready", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        chk("single_exec_active", alu_active, 1);
        chk("single_exec_busy", busy, 1);
        chk("single_exec_rspv", rsp_valid, 0);
        chk("single_alu_a", alu_operand_a, 5);
        chk("single_alu_b", alu_operand_b, 7);
        cyc();
        chk("single_rspv", rsp_valid, 2'b01);
        chk("single_result", rsp_result, 12);
        chk("single_zero", rsp_zero, 0);
        cyc();
        chk("single_idle_rspv", rsp_valid, 0);
        chk("single_idle_busy", busy, 0);

        // Contention: grant order 0,1,0,1
        do_reset();
        set_req(0, 9, 9, OP_SUB);
        set_req(1, 32'hFFFF_FFFF, 1, OP_SLT);
        req_valid = 2'b11;
        #1;
        for (int n = 0; n < 4; n++) begin
            exp_oh = (n % 2 == 0) ? 2'b01 : 2'b10;
            chk("cont_grant", req_ready, exp_oh);
            cyc();
            chk("cont_active", alu_active, 1);
            cyc();
            chk("cont_rspv", rsp_valid, exp_oh);
            chk("cont_result", rsp_result, (n % 2 == 0) ? 0 : 1);
            chk("cont_zero", rsp_zero, (n % 2 == 0) ? 1 : 0);
            cyc();
        end
        req_valid = '0;

        // Back-pressure
        do_reset();
        set_req(0, 100, 23, OP_ADD);
        set_req(1, 1, 1, OP_ADD);
        rsp_ready = '0;
        req_valid = 2'b11;
        #1;
        chk("bp_grant0", req_ready, 2'b01);
        cyc();
        req_valid = 2'b10;
        chk("bp_exec_ready", req_ready, 0);
        cyc();
        held = rsp_result;
        chk("bp_first_result", held, 123);
        for (int n = 0; n < 5; n++) begin
            chk("bp_hold_rspv", rsp_valid, 2'b01);
            chk("bp_hold_result", rsp_result, 123);
            chk("bp_hold_ready", req_ready, 0);
            cyc();
        end
        rsp_ready = 2'b01;
        #1;
        chk("bp_hs_ready", req_ready, 0);
        cyc();
        chk("bp_after_ready", req_ready, 2'b10);
        cyc();
        req_valid = '0;
        cyc();
        chk("bp_r1_rspv", rsp_valid, 2'b10);
        chk("bp_r1_result", rsp_result, 2);
        cyc();
        chk("bp_nonowner_ignored", rsp_valid, 2'b10);
        rsp_ready = 2'b10;
        cyc();
        chk("bp_r1_done", busy, 0);

        // Reset during EXEC
        do_reset();
        set_req(0, 1, 2, OP_ADD);
        req_valid = 2'b01;
        #1;
        cyc();
        chk("mid_in_exec", alu_active, 1);
        rst = 1'b1;
        #1;
        chk("mid_req_ready", req_ready, 0);
        chk("mid_rspv", rsp_valid, 0);
        chk("mid_result", rsp_result, 0);
        chk("mid_alu_a", alu_operand_a, 0);
        chk("mid_alu_b", alu_operand_b, 0);
        chk("mid_alu_ctrl", alu_ctrl, 0);
        chk("mid_active", alu_active, 0);
        chk("mid_busy", busy, 0);
        cyc();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        for (int n = 0; n < 3; n++) begin
            cyc();
            chk("mid_no_rsp", rsp_valid, 0);
        end
        req_valid = 2'b11;
        #1;
        chk("mid_req0_wins", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        cyc();
        cyc();

        // Gating
        do_reset();
        run_op(1, 32'h1234_5678, 32'h0F0F_0F0F, OP_ADD, res, z, act);
        chk("gate_prep_result", res, 32'h2143_6587);
        ra = alu_operand_a;
        rb = alu_operand_b;
        rc = alu_ctrl;
        for (int n = 0; n < 20; n++) begin
            cyc();
            chk("gate_idle_active", alu_active, 0);
            chk("gate_idle_regs", {alu_operand_a, alu_operand_b, alu_ctrl}, {ra, rb, rc});
        end
        run_op(0, 40, 2, OP_SUB, res, z, act);
        chk("gate_active_cycles", act, 1);
        chk("gate_sub_result", res, 38);

        // Undefined control code
        run_op(1, 3, 4, 4'b1111, res, z, act);
        chk("undef_result", res, 0);
        chk("undef_zero", z, 1);

        // Randomized traffic against a transaction-level model
        do_reset();
        last = NR - 1;
        out  = 0;
        own  = 0;
        age  = 0;
        exp_res = '0;
        for (int i = 0; i < NR; i++) pv[i] = 0;
        for (int cycle = 0; cycle < 600; cycle++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
                    pv[i] = 1;
                    pa[i] = $urandom;
                    pb[i] = ($urandom_range(0, 3) == 0) ? pa[i] : $urandom;
                    pc[i] = 4'($urandom_range(0, 15));
                end
                req_valid[i] = pv[i];
                if (pv[i]) set_req(i, pa[i], pb[i], pc[i]);
            end
            rsp_ready = NR'($urandom_range(0, 3));
            #1;
            exp_oh = '0;
            w = -1;
            if (!out) begin
                w = rr_pick(req_valid, last);
                if (w >= 0) exp_oh[w] = 1'b1;
            end
            chk("rnd_req_ready", req_ready, exp_oh);
            exp_oh = '0;
            if (out && age >= 2) exp_oh[own] = 1'b1;
            chk("rnd_rsp_valid", rsp_valid, exp_oh);
            if (out && age >= 2) begin
                chk("rnd_result", rsp_result, exp_res);
                chk("rnd_zero", rsp_zero, (exp_res == '0));
            end
            chk("rnd_active", alu_active, out && age == 1);
            chk("rnd_busy", busy, out);
            if (w >= 0) begin
                out     = 1;
                own     = w;
                age     = 1;
                exp_res = alu_fn(pa[w], pb[w], pc[w]);
                last    = w;
                pv[w]   = 0;
            end else if (out) begin
                if (age >= 2 && rsp_ready[own]) out = 0;
                else if (age < 2) age++;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
